multicycle_main_fsm: RTL and testbench

- Main control state machine for the multi-cycle RV32I core.
- Sequences fetch, decode, execute, memory and writeback over several cycles, and drives every datapath mux select, write enable and the 2-bit alu_op consumed by the ALU decoder.
- Stalls on a ready/valid memory handshake.
- Traps on unsupported opcodes.

---
 rtl/core_ctrl_pkg.sv | 50 +++++
 rtl/branch_cond_eval.sv | 31 +++
 rtl/multicycle_main_fsm.sv | 177 +++++++++++++++++
 tb/tb_multicycle_main_fsm.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_ctrl_pkg.sv
// rtl/core_ctrl_pkg.sv - shared control encodings for the multi-cycle RV32I core
// Holds the main FSM state encoding, the opcodes it decodes, and the select /
// alu_op encodings that the ALU decoder and the datapath agree on.
package core_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11,
    S_JALR     = 4'd12,
    S_LINK     = 4'd13,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_PASS  = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

endpackage

// File: rtl/branch_cond_eval.sv
// rtl/branch_cond_eval.sv - combinational branch condition from funct3 and ALU flags
// Ports:
//   funct3     in  branch type from the instruction
//   zero       in  rs1 - rs2 == 0
//   lt / ltu   in  signed / unsigned rs1 < rs2
//   taken      out branch condition holds
//   bad_funct3 out funct3 is not a defined branch type (010, 011)
module branch_cond_eval (
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  output logic       taken,
  output logic       bad_funct3
);

  always_comb begin
    taken      = 1'b0;
    bad_funct3 = 1'b0;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      3'b100:  taken = lt;
      3'b101:  taken = ~lt;
      3'b110:  taken = ltu;
      3'b111:  taken = ~ltu;
      default: bad_funct3 = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_main_fsm.sv
// rtl/multicycle_main_fsm.sv - main control FSM of the multi-cycle RV32I core
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   op, funct3              instruction fields from the instruction register
//   zero, lt, ltu           ALU comparison flags, used in BRANCH
//   mem_ready               memory has completed the current access
//   mem_req, mem_write      memory request / store qualifier
//   adr_src, ir_write       address mux select, instruction register load
//   pc_write, reg_write     PC and register file write enables
//   alu_src_a/b, result_src datapath mux selects
//   alu_op                  class of operation for the ALU decoder
//   illegal                 sticky trap flag, cleared only by reset
//   state_dbg               current state encoding
module multicycle_main_fsm
  import core_ctrl_pkg::*;
#(
  parameter state_t RESET_STATE = S_FETCH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] alu_op,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  state_t state, state_next;
  logic   br_taken, br_bad;

  branch_cond_eval u_branch_cond_eval (
    .funct3     (funct3),
    .zero       (zero),
    .lt         (lt),
    .ltu        (ltu),
    .taken      (br_taken),
    .bad_funct3 (br_bad)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RESET_STATE;
    else        state <= state_next;
  end

  assign state_dbg = state;

  // Outputs are gated by rst_n so that an access in flight is dropped the
  // moment reset asserts, even though the state register already reads FETCH.
  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RD2;
    result_src = RES_ALUOUT;
    alu_op     = ALU_ADD;
    illegal    = 1'b0;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          mem_req    = 1'b1;
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALURESULT;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
          if (mem_ready) state_next = S_DECODE;
        end
        S_DECODE: begin
          // Branch / JAL target OldPC + imm is parked in ALUOut here.
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_IMM;
          case (op)
            OP_LOAD, OP_STORE: state_next = S_MEMADR;
            OP_R:              state_next = S_EXECR;
            OP_I:              state_next = S_EXECI;
            OP_BRANCH:         state_next = S_BRANCH;
            OP_JAL:            state_next = S_JAL;
            OP_JALR:           state_next = S_JALR;
            OP_LUI:            state_next = S_LUI;
            default:           state_next = S_TRAP;
          endcase
        end
        S_MEMADR: begin
          alu_src_a  = SRCA_RD1;
          alu_src_b  = SRCB_IMM;
          state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
          if (mem_ready) state_next = S_MEMWB;
        end
        S_MEMWB: begin
          result_src = RES_DATA;
          reg_write  = 1'b1;
          state_next = S_FETCH;
        end
        S_MEMWRITE: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          adr_src   = 1'b1;
          if (mem_ready) state_next = S_FETCH;
        end
        S_EXECR: begin
          alu_src_a  = SRCA_RD1;
          alu_op     = ALU_FUNCT;
          state_next = S_ALUWB;
        end
        S_EXECI: begin
          alu_src_a  = SRCA_RD1;
          alu_src_b  = SRCB_IMM;
          alu_op     = ALU_FUNCT;
          state_next = S_ALUWB;
        end
        S_ALUWB: begin
          reg_write  = 1'b1;
          state_next = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a  = SRCA_RD1;
          alu_op     = ALU_SUB;
          pc_write   = br_taken & ~br_bad;
          state_next = br_bad ? S_TRAP : S_FETCH;
        end
        S_JAL: begin
          // PC <- ALUOut (target from DECODE); ALU computes OldPC + 4 for the link.
          alu_src_a  = SRCA_OLDPC;
          alu_src_b  = SRCB_FOUR;
          pc_write   = 1'b1;
          state_next = S_ALUWB;
        end
        S_JALR: begin
          // PC <- rs1 + imm straight from the ALU result.
          alu_src_a  = SRCA_RD1;
          alu_src_b  = SRCB_IMM;
          result_src = RES_ALURESULT;
          pc_write   = 1'b1;
          state_next = S_LINK;
        end
        S_LINK: begin
          // Same link computation as JAL but without reloading the PC.
          alu_src_a  = SRCA_OLDPC;
          alu_src_b  = SRCB_FOUR;
          state_next = S_ALUWB;
        end
        S_LUI: begin
          alu_src_b  = SRCB_IMM;
          alu_op     = ALU_PASS;
          state_next = S_ALUWB;
        end
        S_TRAP: begin
          illegal    = 1'b1;
          state_next = S_TRAP;
        end
        default: state_next = S_TRAP;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// tb/tb_multicycle_main_fsm.sv - scoreboard bench for multicycle_main_fsm
module tb_multicycle_main_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero, lt, ltu, mem_ready;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
  logic       illegal;
  logic [3:0] state_dbg;

  multicycle_main_fsm dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .funct3     (funct3),
    .zero       (zero),
    .lt         (lt),
    .ltu        (ltu),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_write  (mem_write),
    .adr_src    (adr_src),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .result_src (result_src),
    .alu_op     (alu_op),
    .illegal    (illegal),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [18:0] vec;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [18:0] mk(input logic [3:0] st, input logic req, input logic wr,
                                     input logic adr, input logic irw, input logic pcw,
                                     input logic rw, input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [1:0] rs, input logic [1:0] aop, input logic ill);
    return {st, req, wr, adr, irw, pcw, rw, sa, sb, rs, aop, ill};
  endfunction

  // Hand-written per-state expectations
  //                        st   req wr adr irw pcw rw  sa  sb  rs  aop ill
  logic [18:0] RST, F_WAIT, F_GO, DEC, EXR, AWB, MADR, MRD, MWB, MWR;
  logic [18:0] BR_T, BR_N, JALS, JALRS, LINKS, LUIS, TRP;
  initial begin
    RST    = mk(4'd0,  0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0);
    F_WAIT = mk(4'd0,  1, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd2, 2'd0, 0);
    F_GO   = mk(4'd0,  1, 0, 0, 1, 1, 0, 2'd0, 2'd2, 2'd2, 2'd0, 0);
    DEC    = mk(4'd1,  0, 0, 0, 0, 0, 0, 2'd1, 2'd1, 2'd0, 2'd0, 0);
    EXR    = mk(4'd6,  0, 0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd0, 2'd2, 0);
    AWB    = mk(4'd8,  0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 2'd0, 0);
    MADR   = mk(4'd2,  0, 0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd0, 2'd0, 0);
    MRD    = mk(4'd3,  1, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0);
    MWB    = mk(4'd4,  0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd1, 2'd0, 0);
    MWR    = mk(4'd5,  1, 1, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0);
    BR_T   = mk(4'd9,  0, 0, 0, 0, 1, 0, 2'd2, 2'd0, 2'd0, 2'd1, 0);
    BR_N   = mk(4'd9,  0, 0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd0, 2'd1, 0);
    JALS   = mk(4'd10, 0, 0, 0, 0, 1, 0, 2'd1, 2'd2, 2'd0, 2'd0, 0);
    JALRS  = mk(4'd12, 0, 0, 0, 0, 1, 0, 2'd2, 2'd1, 2'd2, 2'd0, 0);
    LINKS  = mk(4'd13, 0, 0, 0, 0, 0, 0, 2'd1, 2'd2, 2'd0, 2'd0, 0);
    LUIS   = mk(4'd11, 0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd0, 2'd3, 0);
    TRP    = mk(4'd15, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 1);
  end

  // Called right after a rising edge: drive this cycle's inputs, queue the
  // outputs the DUT must show during this cycle, then advance to the next edge.
  task automatic cyc(input string name, input logic r, input logic rdy, input logic [18:0] e);
    exp_t x;
    rst_n     = r;
    mem_ready = rdy;
    x.name    = name;
    x.vec     = e;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // Monitor: mid-cycle sample of every output, compared against the queue head.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t x;
      logic [18:0] got;
      x   = q.pop_front();
      got = {state_dbg, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
             alu_src_a, alu_src_b, result_src, alu_op, illegal};
      checks++;
      if (got !== x.vec) begin
        errors++;
        $display("FAIL %s: got %b expected %b (state %0d vs %0d)", x.name, got, x.vec,
                 got[18:15], x.vec[18:15]);
      end
    end
  end

  initial begin
    rst_n = 1'b0; op = 7'd0; funct3 = 3'd0;
    zero = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // reset state, mem_ready ignored while in reset
    cyc("reset", 0, 0, RST);
    cyc("reset_rdy", 0, 1, RST);

    // add x3,x1,x2
    op = 7'b0110011;
    cyc("add_fetch", 1, 1, F_GO);
    cyc("add_decode", 1, 0, DEC);
    cyc("add_execr", 1, 0, EXR);
    cyc("add_aluwb", 1, 0, AWB);

    // lw with three wait cycles in FETCH and MEMREAD
    op = 7'b0000011;
    for (int i = 0; i < 3; i++) cyc("lw_fetch_wait", 1, 0, F_WAIT);
    cyc("lw_fetch", 1, 1, F_GO);
    cyc("lw_decode", 1, 0, DEC);
    cyc("lw_memadr", 1, 0, MADR);
    for (int i = 0; i < 3; i++) cyc("lw_memread_wait", 1, 0, MRD);
    cyc("lw_memread", 1, 1, MRD);
    cyc("lw_memwb", 1, 1, MWB);

    // sw with two wait cycles
    op = 7'b0100011;
    cyc("sw_fetch", 1, 1, F_GO);
    cyc("sw_decode", 1, 1, DEC);
    cyc("sw_memadr", 1, 1, MADR);
    cyc("sw_memwrite_wait", 1, 0, MWR);
    cyc("sw_memwrite_wait", 1, 0, MWR);
    cyc("sw_memwrite", 1, 1, MWR);

    // bne
    op = 7'b1100011; funct3 = 3'b001; zero = 1'b1;
    cyc("bne_fetch", 1, 1, F_GO);
    cyc("bne_decode", 1, 0, DEC);
    cyc("bne_not_taken", 1, 1, BR_N);
    zero = 1'b0;
    cyc("bne_fetch", 1, 1, F_GO);
    cyc("bne_decode", 1, 0, DEC);
    cyc("bne_taken", 1, 0, BR_T);

    // bgeu
    funct3 = 3'b111; ltu = 1'b1;
    cyc("bgeu_fetch", 1, 1, F_GO);
    cyc("bgeu_decode", 1, 0, DEC);
    cyc("bgeu_not_taken", 1, 0, BR_N);
    ltu = 1'b0;
    cyc("bgeu_fetch", 1, 1, F_GO);
    cyc("bgeu_decode", 1, 0, DEC);
    cyc("bgeu_taken", 1, 0, BR_T);

    // jal, jalr, lui
    op = 7'b1101111;
    cyc("jal_fetch", 1, 1, F_GO);
    cyc("jal_decode", 1, 0, DEC);
    cyc("jal_jal", 1, 0, JALS);
    cyc("jal_aluwb", 1, 0, AWB);
    op = 7'b1100111;
    cyc("jalr_fetch", 1, 1, F_GO);
    cyc("jalr_decode", 1, 0, DEC);
    cyc("jalr_jalr", 1, 0, JALRS);
    cyc("jalr_link", 1, 0, LINKS);
    cyc("jalr_aluwb", 1, 0, AWB);
    op = 7'b0110111;
    cyc("lui_fetch", 1, 1, F_GO);
    cyc("lui_decode", 1, 0, DEC);
    cyc("lui_lui", 1, 0, LUIS);
    cyc("lui_aluwb", 1, 0, AWB);

    // reset mid-MEMREAD
    op = 7'b0000011;
    cyc("rlw_fetch", 1, 1, F_GO);
    cyc("rlw_decode", 1, 0, DEC);
    cyc("rlw_memadr", 1, 0, MADR);
    cyc("rlw_memread", 1, 0, MRD);
    cyc("rlw_reset", 0, 1, RST);
    cyc("rlw_reset_hold", 0, 1, RST);
    cyc("rlw_release", 1, 0, F_WAIT);

    // undefined branch funct3 traps without writing the PC
    op = 7'b1100011; funct3 = 3'b010;
    cyc("badbr_fetch", 1, 1, F_GO);
    cyc("badbr_decode", 1, 0, DEC);
    cyc("badbr_branch", 1, 0, BR_N);
    cyc("badbr_trap", 1, 1, TRP);
    cyc("badbr_reset", 0, 0, RST);

    // illegal opcode: sticky until reset
    op = 7'b0000000;
    cyc("ill_fetch", 1, 1, F_GO);
    cyc("ill_decode", 1, 1, DEC);
    for (int i = 0; i < 10; i++) cyc("ill_trap", 1, 1, TRP);
    cyc("ill_reset", 0, 1, RST);
    cyc("ill_release", 1, 0, F_WAIT);

    begin : drain
      int n;
      n = 0;
      while (q.size() > 0 && n < 20) begin
        @(posedge clk);
        n++;
      end
      if (q.size() > 0) begin
        errors++;
        checks++;
        $display("FAIL drain: %0d expectations left, required 0", q.size());
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
